vn_lut_pingpong_loader: RTL
===========================

Name: vn_lut_pingpong_loader

Overview:
- Parametrised successor to the single-bank VN IB-LUT cells: a double-buffered (active/shadow) variable-node IB-LUT with N replicated read ports.
- Holds an on-chip load FSM. A new quantisation table streams into the shadow set while decoding keeps reading the active set; a swap handshake then promotes the shadow set.
- Sits between the IB-LUT table loader (per-iteration table updates) and the VN units of the layered decoder.

Parameters:
- MSG_BITWIDTH, 3, bits per quantised message (table entry width)
- PAGE_NUM, 64, entries per table set (VN load cycles); need not be a power of two
- ADDR_BITWIDTH, 6, read-address width; must satisfy 2**ADDR_BITWIDTH >= PAGE_NUM
- RD_PORT_NUM, 2, independent read ports, each a replicated copy of the active set
- PTR_BITWIDTH, $clog2(PAGE_NUM), width of the write pointer (derived; do not override)

Ports:
- sys_clk  in  1  single clock for all logic and memory writes
- rst  in  1  reset, synchronous, active-high
- load_start  in  1  pulse: begin loading the shadow set
- load_abort  in  1  pulse: abandon the load in progress
- load_valid  in  1  load_data is valid
- load_data  in  MSG_BITWIDTH  table entry, in address order 0..PAGE_NUM-1
- load_ready  out  1  high only in LOAD
- load_done  out  1  one-cycle pulse after the last entry is accepted
- swap_req  in  1  request to promote the shadow set
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- table_valid  out  1  an active set has been loaded since reset
- rd_en  in  RD_PORT_NUM  per-port read strobe
- rd_addr  in  RD_PORT_NUM*ADDR_BITWIDTH  packed per-port addresses; port p uses bits [p*ADDR_BITWIDTH +: ADDR_BITWIDTH]
- rd_data  out  RD_PORT_NUM*MSG_BITWIDTH  packed per-port read data
- rd_valid  out  RD_PORT_NUM  per-port data valid

Behaviour:
- Reset: state=IDLE, active_set=0, wr_ptr=0, shadow_full=0, table_valid=0. load_ready, load_done, swap_ack, rd_valid and rd_data are all 0. Memory contents are not reset.
- FSM states are IDLE, LOAD and FULL.
- IDLE:
  - load_start=1 -> LOAD, wr_ptr=0.
  - swap_req is ignored (no swap_ack).
- LOAD:
  - load_ready=1.
  - On load_valid & load_ready: write mem[~active_set][wr_ptr] = load_data, then wr_ptr++.
  - Accepting the entry with wr_ptr==PAGE_NUM-1 -> FULL, wr_ptr=0, and load_done=1 in the following cycle.
  - load_abort=1 -> IDLE, wr_ptr=0. The shadow set is partially written and the active set is untouched.
  - load_abort wins over a same-cycle load_valid: that data is not written.
  - load_start in LOAD is ignored.
- FULL:
  - swap_req=1 -> active_set toggles at the clock edge, state returns to IDLE, table_valid=1, and swap_ack=1 for exactly the next cycle.
  - load_start in FULL -> LOAD, overwriting the not-yet-swapped shadow set (restart allowed).
  - swap_req and load_start in the same cycle: swap wins and load_start is dropped.
- Reads (every state, including LOAD):
  - Latency is 1 cycle.
  - rd_en[p]=1 in cycle t gives rd_valid[p]=1 and rd_data[p]=mem[active_set][rd_addr[p]] in cycle t+1, where active_set is its value during cycle t.
  - A read issued in the swap cycle returns old-set data.
  - Reads never observe shadow writes.
  - rd_addr >= PAGE_NUM returns 0, with rd_valid still asserted.
  - rd_en=0 drives rd_valid=0; rd_data holds its last value.
  - Reads before table_valid return the memory contents but are legal.
- rst asserted mid-LOAD -> IDLE. Whatever was written so far is discarded logically; the set is treated as not loaded.
- Memory: 2 sets x RD_PORT_NUM replicas, each PAGE_NUM x MSG_BITWIDTH. Every write goes to all replicas of the shadow set. Implement as LUTRAM: asynchronous read plus an output register.

Decomposition:
- Shared package vn_lut_pkg holds:
  - FSM state enum (IDLE/LOAD/FULL)
  - localparam SET_NUM=2
  - a clog2-based function for the pointer width
- Sub-module vn_lut_set_bank: one PAGE_NUM x MSG_BITWIDTH LUTRAM with an asynchronous read port and a synchronous write port. Instantiate it 2*RD_PORT_NUM times.
- The FSM and read registers stay in the top module.

Test Plan:
- Cold load:
  - Stimulus: reset, load_start, stream 64 entries (data = addr mod 8) with load_valid held high, then swap_req.
  - Response: load_done 64 cycles after the first accept, then swap_ack; table_valid=1; port0 reading addr 13 returns 5 one cycle later.
- Background reload:
  - Stimulus: with set A active (data = addr mod 8), load data = 7-(addr mod 8) while port1 reads addr 3 every cycle.
  - Response: port1 reads 3 until the swap cycle; from the cycle after the swap it reads 4.
- Backpressure gaps:
  - Stimulus: drop load_valid on alternate cycles.
  - Response: wr_ptr advances only on accept; all 64 entries are correct; load_done comes after the 64th accept.
- Abort:
  - Stimulus: load_abort after 20 entries, then swap_req.
  - Response: no swap_ack; the active table is unchanged; load_ready falls the next cycle.
- Conflicts:
  - Stimulus: in FULL, assert swap_req and load_start together; separately, assert rst at wr_ptr=40.
  - Response: the swap occurs and the state is IDLE; after rst, all outputs are 0 and table_valid=0.
- Read edge:
  - Stimulus: rd_addr=63 and rd_addr=64 with PAGE_NUM=64 and ADDR_BITWIDTH=7.
  - Response: entry 63, and 0 with rd_valid=1.

Source files
------------

// File: rtl/vn_lut_pkg.sv
// Shared definitions for the double-buffered variable-node IB-LUT:
// load FSM states, table set count and pointer-width helper.
package vn_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } vn_lut_state_e;

    localparam int SET_NUM = 2;

    // Never returns 0, so a single-entry table still gets a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vn_lut_set_bank.sv
// One table replica: PAGE_NUM x MSG_BITWIDTH LUTRAM with a synchronous write
// port and an asynchronous read port that returns 0 for out-of-range addresses.
module vn_lut_set_bank #(
    parameter int MSG_BITWIDTH  = 3,
    parameter int PAGE_NUM      = 64,
    parameter int ADDR_BITWIDTH = 6,
    parameter int PTR_BITWIDTH  = 6
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [PTR_BITWIDTH-1:0]  wr_addr_i,
    input  logic [MSG_BITWIDTH-1:0]  wr_data_i,
    input  logic [ADDR_BITWIDTH-1:0] rd_addr_i,
    output logic [MSG_BITWIDTH-1:0]  rd_data_o
);

    logic [MSG_BITWIDTH-1:0] mem_q [PAGE_NUM];
    logic [PTR_BITWIDTH-1:0] rd_idx;
    logic                    rd_in_range;

    assign rd_idx      = rd_addr_i[PTR_BITWIDTH-1:0];
    assign rd_in_range = (32'(rd_addr_i) < 32'(PAGE_NUM));

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_in_range) begin
            rd_data_o = mem_q[rd_idx];
        end
    end

endmodule

// File: rtl/vn_lut_pingpong_loader.sv
// Double-buffered VN IB-LUT: a new table streams into the shadow set while the
// read ports keep using the active set; a swap handshake then promotes it.
module vn_lut_pingpong_loader
    import vn_lut_pkg::*;
#(
    parameter int MSG_BITWIDTH  = 3,
    parameter int PAGE_NUM      = 64,
    parameter int ADDR_BITWIDTH = 6,
    parameter int RD_PORT_NUM   = 2,
    parameter int PTR_BITWIDTH  = ptr_width(PAGE_NUM)
) (
    input  logic                                 sys_clk,
    input  logic                                 rst,
    input  logic                                 load_start,
    input  logic                                 load_abort,
    input  logic                                 load_valid,
    input  logic [MSG_BITWIDTH-1:0]              load_data,
    output logic                                 load_ready,
    output logic                                 load_done,
    input  logic                                 swap_req,
    output logic                                 swap_ack,
    output logic                                 table_valid,
    input  logic [RD_PORT_NUM-1:0]               rd_en,
    input  logic [RD_PORT_NUM*ADDR_BITWIDTH-1:0] rd_addr,
    output logic [RD_PORT_NUM*MSG_BITWIDTH-1:0]  rd_data,
    output logic [RD_PORT_NUM-1:0]               rd_valid,
    output logic [1:0]                           dbg_state_o,
    output logic [PTR_BITWIDTH-1:0]              dbg_wr_ptr_o
);

    localparam logic [PTR_BITWIDTH-1:0] LAST_PTR = PTR_BITWIDTH'(PAGE_NUM - 1);

    // Handshake: a load entry is accepted on a cycle where load_valid and
    // load_ready are both high and load_abort is low; load_ready depends only
    // on the registered state, never on load_valid.
    vn_lut_state_e                   state_q, state_d;
    logic                            active_set_q, active_set_d;
    logic [PTR_BITWIDTH-1:0]         wr_ptr_q, wr_ptr_d;
    logic                            table_valid_q, table_valid_d;
    logic                            load_done_q, load_done_d;
    logic                            swap_ack_q, swap_ack_d;
    logic                            wr_fire;
    logic [RD_PORT_NUM-1:0]          rd_valid_q;
    logic [RD_PORT_NUM*MSG_BITWIDTH-1:0] rd_data_q, rd_data_d;
    logic [MSG_BITWIDTH-1:0]         bank_rd [SET_NUM][RD_PORT_NUM];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            active_set_q  <= 1'b0;
            wr_ptr_q      <= '0;
            table_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_set_q  <= active_set_d;
            wr_ptr_q      <= wr_ptr_d;
            table_valid_q <= table_valid_d;
            load_done_q   <= load_done_d;
            swap_ack_q    <= swap_ack_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        active_set_d  = active_set_q;
        wr_ptr_d      = wr_ptr_q;
        table_valid_d = table_valid_q;
        load_done_d   = 1'b0;
        swap_ack_d    = 1'b0;
        wr_fire       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                // Abort takes priority, so a same-cycle entry is dropped.
                if (load_abort) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                end else if (load_valid) begin
                    wr_fire = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d     = ST_FULL;
                        wr_ptr_d    = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (swap_req) begin
                    state_d       = ST_IDLE;
                    active_set_d  = ~active_set_q;
                    table_valid_d = 1'b1;
                    swap_ack_d    = 1'b1;
                end else if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every write lands in all replicas of the set that is not active.
    for (genvar s = 0; s < SET_NUM; s++) begin : g_set
        for (genvar p = 0; p < RD_PORT_NUM; p++) begin : g_port
            vn_lut_set_bank #(
                .MSG_BITWIDTH (MSG_BITWIDTH),
                .PAGE_NUM     (PAGE_NUM),
                .ADDR_BITWIDTH(ADDR_BITWIDTH),
                .PTR_BITWIDTH (PTR_BITWIDTH)
            ) u_bank (
                .clk_i    (sys_clk),
                .wr_en_i  (wr_fire & ((s == 0) ? active_set_q : ~active_set_q)),
                .wr_addr_i(wr_ptr_q),
                .wr_data_i(load_data),
                .rd_addr_i(rd_addr[p*ADDR_BITWIDTH +: ADDR_BITWIDTH]),
                .rd_data_o(bank_rd[s][p])
            );
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        for (int p = 0; p < RD_PORT_NUM; p++) begin
            if (rd_en[p]) begin
                rd_data_d[p*MSG_BITWIDTH +: MSG_BITWIDTH] = bank_rd[active_set_q][p];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    assign load_ready   = (state_q == ST_LOAD);
    assign load_done    = load_done_q;
    assign swap_ack     = swap_ack_q;
    assign table_valid  = table_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign dbg_state_o  = state_q;
    assign dbg_wr_ptr_o = wr_ptr_q;

endmodule
